// File: rtl/sprite_rom_pkg.sv
// Shared constants and FSM state type for the sprite ROM arbiter.
// Holds the default image geometry and the ROM address/data widths.
package sprite_rom_pkg;
   localparam int IMG_W_DEF = 584;
   localparam int IMG_H_DEF = 167;
   localparam int ROW_W     = 8;
   localparam int COL_W     = 10;
   localparam int COLOR_W   = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating priority pointer.
// The pointer moves past the winner only when something is granted.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   win_idx_o,
   output logic [IDX_W-1:0]   ptr_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             found;
   int               idx;

   // Every grant implies its request, so any grant bit is a transfer.
   always_comb begin
      gnt_o     = '0;
      win_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            win_idx_o  = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         if (int'(win_idx_o) == NUM_REQ - 1) ptr_d = '0;
         else                                ptr_d = win_idx_o + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous image ROM between NUM_REQ requesters, round-robin.
// Handshake: a transfer happens on a rising edge where req[i] and gnt[i] are both high; the requester holds req/row/col until then.
module sprite_rom_arbiter
   import sprite_rom_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IMG_W   = IMG_W_DEF,
   parameter int IMG_H   = IMG_H_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*ROW_W-1:0] req_row,
   input  logic [NUM_REQ*COL_W-1:0] req_col,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [ROW_W-1:0]         rom_row,
   output logic [COL_W-1:0]         rom_col,
   input  logic [COLOR_W-1:0]       rom_color,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [COLOR_W-1:0]       rsp_color,
   output logic                     rsp_oob,
   output logic                     busy,
   output state_e                   dbg_state_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_q, state_d;
   logic                 grant_allow;
   logic [NUM_REQ-1:0]   arb_req;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     ptr_unused;
   logic                 transfer;
   logic [ROW_W-1:0]     win_row;
   logic [COL_W-1:0]     win_col;
   logic                 win_oob;

   logic                 s1_v_q, s2_v_q;
   logic [IDX_W-1:0]     s1_idx_q, s2_idx_q;
   logic                 s1_oob_q, s2_oob_q;
   logic [ROW_W-1:0]     rom_row_q;
   logic [COL_W-1:0]     rom_col_q;
   logic [NUM_REQ-1:0]   rsp_valid_q;
   logic [COLOR_W-1:0]   rsp_color_q;
   logic                 rsp_oob_q;

   // Gating on en directly keeps the falling-en cycle grant-free.
   assign grant_allow = (state_q == ST_ACTIVE) && en;
   assign arb_req     = req & {NUM_REQ{grant_allow}};

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (arb_req),
      .gnt_o     (gnt),
      .win_idx_o (win_idx),
      .ptr_o     (ptr_unused)
   );

   assign transfer = |gnt;
   assign win_row  = req_row[int'(win_idx)*ROW_W +: ROW_W];
   assign win_col  = req_col[int'(win_idx)*COL_W +: COL_W];
   assign win_oob  = (int'(win_row) >= IMG_H) || (int'(win_col) >= IMG_W);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (en) state_d = ST_ACTIVE;
         ST_ACTIVE: if (!en) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (en)                        state_d = ST_ACTIVE;
            else if (!s1_v_q && !s2_v_q)   state_d = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Stage 1 tags the address just issued; stage 2 aligns with ROM data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_row_q   <= '0;
         rom_col_q   <= '0;
         s1_v_q      <= 1'b0;
         s1_idx_q    <= '0;
         s1_oob_q    <= 1'b0;
         s2_v_q      <= 1'b0;
         s2_idx_q    <= '0;
         s2_oob_q    <= 1'b0;
         rsp_valid_q <= '0;
         rsp_color_q <= '0;
         rsp_oob_q   <= 1'b0;
      end else begin
         if (transfer) begin
            rom_row_q <= win_row;
            rom_col_q <= win_col;
         end
         s1_v_q      <= transfer;
         s1_idx_q    <= win_idx;
         s1_oob_q    <= win_oob;
         s2_v_q      <= s1_v_q;
         s2_idx_q    <= s1_idx_q;
         s2_oob_q    <= s1_oob_q;
         rsp_valid_q <= s2_v_q ? (NUM_REQ'(1) << s2_idx_q) : '0;
         if (s2_v_q) begin
            rsp_color_q <= s2_oob_q ? '0 : rom_color;
            rsp_oob_q   <= s2_oob_q;
         end
      end
   end

   assign rom_row     = rom_row_q;
   assign rom_col     = rom_col_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_color   = rsp_color_q;
   assign rsp_oob     = rsp_oob_q;
   assign busy        = (state_q != ST_IDLE) || s1_v_q || s2_v_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter with a behavioural one-cycle ROM.
// Expected responses are queued when a grant is predicted and popped as responses appear.
module tb_sprite_rom_arbiter;
   import sprite_rom_pkg::*;

   localparam int N  = 4;
   localparam int TW = 584;
   localparam int TH = 167;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [N-1:0]  req;
   logic [N*8-1:0]  req_row;
   logic [N*10-1:0] req_col;
   logic [N-1:0]  gnt;
   logic [7:0]    rom_row;
   logic [9:0]    rom_col;
   logic [11:0]   rom_color;
   logic [N-1:0]  rsp_valid;
   logic [11:0]   rsp_color;
   logic          rsp_oob;
   logic          busy;
   state_e        dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int mdl_ptr  = 0;
   logic grant_ok = 1'b0;
   logic [7:0] rq_row [N];
   logic [9:0] rq_col [N];
   // {issue cycle[15:0], onehot[3:0], oob, color[11:0]}
   logic [32:0] exp_q [$];

   sprite_rom_arbiter #(.NUM_REQ(N), .IMG_W(TW), .IMG_H(TH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req         (req),
      .req_row     (req_row),
      .req_col     (req_col),
      .gnt         (gnt),
      .rom_row     (rom_row),
      .rom_col     (rom_col),
      .rom_color   (rom_color),
      .rsp_valid   (rsp_valid),
      .rsp_color   (rsp_color),
      .rsp_oob     (rsp_oob),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] rom_model(input int a);
      if (a == 0)    return 12'hFFF;
      if (a == 3445) return 12'h62F;
      return 12'(a) ^ 12'h5A5;
   endfunction

   always @(posedge clk) rom_color <= rom_model(int'(rom_row) * TW + int'(rom_col));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [3:0] rr_pick(input logic [3:0] r);
      for (int k = 0; k < N; k++) begin
         int i = (mdl_ptr + k) % N;
         if (r[i]) return 4'(1 << i);
      end
      return 4'b0;
   endfunction

   task automatic pack_addr();
      for (int i = 0; i < N; i++) begin
         req_row[i*8 +: 8]   = rq_row[i];
         req_col[i*10 +: 10] = rq_col[i];
      end
   endtask

   // One cycle: drive, check gnt at negedge, queue the predicted response, pass the edge.
   task automatic step(input logic [3:0] r, output logic [3:0] g, output logic [3:0] g_obs);
      int  wi;
      logic oob;
      logic [11:0] col;
      req = r;
      pack_addr();
      @(negedge clk);
      g     = grant_ok ? rr_pick(r) : 4'b0;
      g_obs = gnt;
      check_eq("gnt", 32'(gnt), 32'(g));
      if (g != 4'b0) begin
         wi = 0;
         for (int i = 0; i < N; i++) if (g[i]) wi = i;
         oob = (int'(rq_row[wi]) >= TH) || (int'(rq_col[wi]) >= TW);
         col = oob ? 12'h000 : rom_model(int'(rq_row[wi]) * TW + int'(rq_col[wi]));
         exp_q.push_back({16'(cyc), g, oob, col});
         mdl_ptr = (wi + 1) % N;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty();
      logic [3:0] g, go;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(4'b0, g, go);
      step(4'b0, g, go);
      check_eq("drain_queue", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      en       = 1'b0;
      req      = '0;
      grant_ok = 1'b0;
      mdl_ptr  = 0;
      exp_q.delete();
      #1;
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_rom_addr", 32'({rom_row, rom_col}), 32'd0);
      check_eq("rst_rsp", 32'({rsp_oob, rsp_color}), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      @(posedge clk);
      #1;
      grant_ok = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rsp_valid !== 4'b0) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check_eq("rsp_latency", 32'(16'(cyc) - e[32:17]), 32'd3);
            check_eq("rsp_valid", 32'(rsp_valid), 32'(e[16:13]));
            check_eq("rsp_oob", 32'(rsp_oob), 32'(e[12]));
            check_eq("rsp_color", 32'(rsp_color), 32'(e[11:0]));
         end
      end
   end

   initial begin
      logic [3:0] g, go, pend;
      rst_n = 1'b0;
      en    = 1'b0;
      req   = '0;
      for (int i = 0; i < N; i++) begin
         rq_row[i] = '0;
         rq_col[i] = '0;
      end
      pack_addr();
      repeat (2) @(posedge clk);
      apply_reset();

      // Single request at origin
      step(4'b0001, g, go);
      wait_empty();

      // Requester 2 at row 5 col 525
      rq_row[2] = 8'd5;
      rq_col[2] = 10'd525;
      step(4'b0100, g, go);
      wait_empty();

      // Out-of-bounds row, then out-of-bounds column
      rq_row[1] = 8'd167;
      rq_col[1] = 10'd0;
      step(4'b0010, g, go);
      rq_row[1] = 8'd0;
      rq_col[1] = 10'd584;
      step(4'b0010, g, go);
      rq_row[1] = 8'd166;
      rq_col[1] = 10'd583;
      step(4'b0010, g, go);
      wait_empty();

      // All four held for 8 cycles from a fresh pointer
      apply_reset();
      for (int i = 0; i < N; i++) begin
         rq_row[i] = 8'(10 + i);
         rq_col[i] = 10'(100 * i + 7);
      end
      for (int i = 0; i < 8; i++) begin
         step(4'b1111, g, go);
         check_eq("rr_order", 32'(go), 32'(1 << (i % 4)));
      end
      wait_empty();

      // Random pending requests; each holds its address until granted
      pend = '0;
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i]   = 1'b1;
               rq_row[i] = 8'($urandom_range(0, 170));
               rq_col[i] = 10'($urandom_range(0, 590));
            end
         end
         step(pend, g, go);
         pend = pend & ~g;
      end
      wait_empty();

      // Drop en after two transfers
      step(4'b0011, g, go);
      step(4'b0011 & ~g, g, go);
      en       = 1'b0;
      grant_ok = 1'b0;
      check_eq("busy_after_en_drop", 32'(busy), 32'd1);
      for (int i = 0; i < 6; i++) step(4'b1111, g, go);
      check_eq("drop_queue", 32'(exp_q.size()), 32'd0);
      check_eq("drop_busy", 32'(busy), 32'd0);
      check_eq("drop_state", 32'(dbg_state), 32'(ST_IDLE));

      // Reset one cycle after a transfer discards it
      en = 1'b1;
      step(4'b0000, g, go);
      grant_ok  = 1'b1;
      rq_row[2] = 8'd5;
      rq_col[2] = 10'd525;
      step(4'b0100, g, go);
      @(negedge clk);
      rst_n    = 1'b0;
      en       = 1'b0;
      req      = '0;
      grant_ok = 1'b0;
      exp_q.delete();
      #1;
      check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("midrst_rom_addr", 32'({rom_row, rom_col}), 32'd0);
      check_eq("midrst_rsp", 32'({rsp_oob, rsp_color}), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("post_rst_valid", 32'(rsp_valid), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one image ROM.
REQ-002 SHALL have parameter IMG_W, default 584: image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 167: image height in rows.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1: grants permitted while high.
REQ-007 SHALL have port req, input, NUM_REQ: per-requester read request.
REQ-008 SHALL have port req_row, input, NUM_REQ*8: packed row per requester.
REQ-009 SHALL have port req_col, input, NUM_REQ*10: packed column per requester.
REQ-010 SHALL have port gnt, output, NUM_REQ: combinational one-hot grant.
REQ-011 SHALL have port rom_row, output, 8: registered ROM row address.
REQ-012 SHALL have port rom_col, output, 10: registered ROM column address.
REQ-013 SHALL have port rom_color, input, 12: ROM data, one clock after address.
REQ-014 SHALL have port rsp_valid, output, NUM_REQ: one-hot response strobe.
REQ-015 SHALL have port rsp_color, output, 12: response pixel.
REQ-016 SHALL have port rsp_oob, output, 1: response address was out of bounds.
REQ-017 SHALL have port busy, output, 1: pipeline non-empty or state not IDLE.

Function
REQ-018 Transfer SHALL occur on an edge where req[i] and gnt[i] are both high; requester SHALL hold req, row and column stable until then.
REQ-019 gnt SHALL be at most one-hot, zero when state is not ACTIVE or en is low, and SHALL depend only on req, state, en and the priority pointer.
REQ-020 Arbitration SHALL be round-robin: search starts at the pointer; after a transfer from i, pointer becomes (i+1) mod NUM_REQ; pointer is unchanged with no transfer.
REQ-021 On transfer, rom_row/rom_col SHALL load the winner's address; otherwise they hold their value.
REQ-022 Address SHALL be out of bounds (oob) when row >= IMG_H or col >= IMG_W.
REQ-023 Pipeline: edge E transfer; E+1 ROM samples the address; at E+2 rsp_color <= (oob ? 12'h000 : rom_color), rsp_oob <= oob, rsp_valid <= onehot(winner); valid for exactly one cycle.
REQ-024 Throughput SHALL be one transfer per cycle; back-to-back responses SHALL keep issue order.
REQ-025 FSM states SHALL be IDLE, ACTIVE and DRAIN.
REQ-026 FSM transition IDLE->ACTIVE SHALL occur when en is high.
REQ-027 FSM transition ACTIVE->DRAIN SHALL occur when en is low.
REQ-028 FSM transition DRAIN->IDLE SHALL occur when both pipeline stages are empty; DRAIN->ACTIVE SHALL occur if en rises first.
REQ-029 In-flight responses SHALL complete in DRAIN; no new grants SHALL be issued.
REQ-030 busy SHALL be low only in IDLE with an empty pipeline.
REQ-031 A request SHALL NOT be granted in the same cycle en falls.

Reset
REQ-032 Reset assertion SHALL immediately clear gnt, rsp_valid, rsp_color, rsp_oob, rom_row, rom_col, busy, pointer and pipeline tags; state SHALL be IDLE.
REQ-033 Reset mid-operation SHALL discard in-flight reads; no rsp_valid SHALL follow release.
REQ-034 First grant after release SHALL require a rising edge with rst_n high and en high (IDLE->ACTIVE), granting on the following cycle.

Structure
REQ-035 Shared package sprite_rom_pkg SHALL hold the default IMG_W/IMG_H, the address widths (8/10), the color width (12) and the state enum.
REQ-036 Sub-module rr_arbiter SHALL implement the pointer and one-hot grant (REQ-020), parameterised by NUM_REQ.

Verification
REQ-037 With en=1 and req[0] only at row 0 col 0, and the ROM model returning 12'hFFF, the bench SHALL check that gnt[0] is high and, 2 edges after transfer, rsp_valid=4'b0001 and rsp_color=12'hFFF.
REQ-038 With req[2] at row 5 col 525 (address 3445), the bench SHALL check rsp_color=12'h62F and rsp_valid=4'b0100.
REQ-039 With all four requesters held high for 8 cycles, the bench SHALL check grant order 0,1,2,3,0,1,2,3, with one response per cycle in the same order.
REQ-040 With req[1] at row 167 col 0, then row 0 col 584, the bench SHALL check rsp_oob=1 and rsp_color=12'h000 for both.
REQ-041 With en dropped after 2 transfers, the bench SHALL check that both responses still arrive, that gnt stays 0, and that busy falls after DRAIN->IDLE.
REQ-042 With rst_n pulsed low one cycle after a transfer, the bench SHALL check that outputs clear immediately and no rsp_valid appears afterward.
